// File: rtl/da_platform_pkg.sv
// Shared DAC-platform constants and the fetch-state encoding.
package da_platform_pkg;

  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned FRAME_SLOTS = 64;
  localparam int unsigned UNDERRUN_W  = 16;
  localparam int unsigned BIT_CNT_W   = $clog2(FRAME_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_READY = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/dac_frame_timer.sv
// BCK/LRCK generator: BCK toggles every CLK_DIV clocks, one frame = FRAME_SLOTS BCK periods.
module dac_frame_timer
  import da_platform_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic running,
  output logic dac_bck,
  output logic dac_lrck,
  output logic bck_fall_c,
  output logic frame_start_c
);

  localparam int unsigned DIV_W = 8;

  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 tick_c;

  assign tick_c        = running && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bck_fall_c    = tick_c && dac_bck;
  // Falling edge that wraps the slot counter starts the next left slot.
  assign frame_start_c = bck_fall_c && (bit_cnt == BIT_CNT_W'(FRAME_SLOTS - 1));
  // Upper half of the frame is the right channel.
  assign dac_lrck      = bit_cnt[BIT_CNT_W-1];

  // Divider, bit clock and slot counter; everything parks at 0 while stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      dac_bck <= 1'b0;
      bit_cnt <= '0;
    end else if (!running) begin
      div_cnt <= '0;
      dac_bck <= 1'b0;
      bit_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
      dac_bck <= ~dac_bck;
      if (dac_bck) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/slot_dac_serializer.sv
// Pulls L/R sample bytes from the tracking FIFO and shifts them out left-justified.
module slot_dac_serializer
  import da_platform_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SAMPLE_BYTES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic                  dac_bck,
  output logic                  dac_lrck,
  output logic                  dac_sdata,
  output logic [UNDERRUN_W-1:0] underrun_count,
  output logic                  running
);

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned SAMPLE_W    = BYTE_W * SAMPLE_BYTES;
  localparam int unsigned STAGE_BYTES = 2 * SAMPLE_BYTES;
  localparam int unsigned STAGE_W     = BYTE_W * STAGE_BYTES;
  localparam int unsigned FRAME_W     = FRAME_SLOTS;
  localparam int unsigned CNT_W       = $clog2(STAGE_BYTES + 1);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic               rd_pend;
  logic [CNT_W-1:0]   issued_cnt;
  logic [CNT_W-1:0]   byte_cnt;
  logic [STAGE_W-1:0] staging;
  logic [FRAME_W-1:0] shift_q;
  logic [FRAME_W-1:0] staged_frame_c;

  logic bck_fall_c;
  logic frame_start_c;
  logic last_byte_c;
  logic start_c;
  logic load_c;
  logic stop_c;
  logic underrun_c;
  logic pop_c;

  dac_frame_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk           (clk),
    .reset         (reset),
    .running       (running),
    .dac_bck       (dac_bck),
    .dac_lrck      (dac_lrck),
    .bck_fall_c    (bck_fall_c),
    .frame_start_c (frame_start_c)
  );

  // Frame decisions; a byte landing on the boundary cycle still counts as not ready.
  always_comb begin
    last_byte_c = rd_pend && (byte_cnt == CNT_W'(STAGE_BYTES - 1));
    start_c     = !running && enable && (state_q == ST_READY);
    load_c      = frame_start_c && enable && (state_q == ST_READY);
    stop_c      = frame_start_c && !enable;
    underrun_c  = frame_start_c && enable && (state_q != ST_READY);
    // Pops alternate with idle cycles so fifo_empty is always fresh when sampled.
    pop_c       = (state_q == ST_FETCH) && !fifo_empty && !fifo_read &&
                  (issued_cnt < CNT_W'(STAGE_BYTES));
  end

  // Left sample at the top of the frame, right sample at the top of the second slot half.
  always_comb begin
    staged_frame_c = (FRAME_W'(staging[STAGE_W-1 -: SAMPLE_W]) << (FRAME_W - SAMPLE_W)) |
                     (FRAME_W'(staging[SAMPLE_W-1:0]) << (SLOT_BITS - SAMPLE_W));
  end

  // Fetch FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_FETCH;
      ST_FETCH: if (last_byte_c) state_d = ST_READY;
      ST_READY: if (load_c || start_c) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Fetch FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FIFO pop strobe, byte capture and staging; partial bytes survive an underrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_read  <= 1'b0;
      rd_pend    <= 1'b0;
      issued_cnt <= '0;
      byte_cnt   <= '0;
      staging    <= '0;
    end else begin
      fifo_read <= pop_c;
      rd_pend   <= fifo_read;
      if (rd_pend) staging <= {staging[STAGE_W-BYTE_W-1:0], fifo_data};
      if (load_c || start_c) begin
        issued_cnt <= '0;
        byte_cnt   <= '0;
      end else begin
        if (pop_c)   issued_cnt <= issued_cnt + CNT_W'(1);
        if (rd_pend) byte_cnt   <= byte_cnt + CNT_W'(1);
      end
    end
  end

  // Run flag, output shift register and saturating underrun counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running        <= 1'b0;
      shift_q        <= '0;
      underrun_count <= '0;
    end else begin
      if (start_c)     running <= 1'b1;
      else if (stop_c) running <= 1'b0;

      if (start_c || load_c)          shift_q <= staged_frame_c;
      else if (stop_c || underrun_c)  shift_q <= '0;
      else if (bck_fall_c)            shift_q <= shift_q << 1;

      if (underrun_c && (underrun_count != '1))
        underrun_count <= underrun_count + UNDERRUN_W'(1);
    end
  end

  assign dac_sdata = shift_q[FRAME_W-1];

endmodule

// File: tb/tb_slot_dac_serializer.sv
// Directed bench: FIFO model, frame deserializer, vector tables plus corner sequences.
module tb_slot_dac_serializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_read;
  logic        dac_bck;
  logic        dac_lrck;
  logic        dac_sdata;
  logic        running;
  logic [15:0] underrun_count;

  slot_dac_serializer #(
    .CLK_DIV      (4),
    .SAMPLE_BYTES (3)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .fifo_data      (fifo_data),
    .fifo_empty     (fifo_empty),
    .fifo_read      (fifo_read),
    .dac_bck        (dac_bck),
    .dac_lrck       (dac_lrck),
    .dac_sdata      (dac_sdata),
    .underrun_count (underrun_count),
    .running        (running)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] LRCK_EXP = 64'h0000_0000_FFFF_FFFF;

  typedef struct {
    int unsigned push_n;
    int unsigned push_delay;
    logic [47:0] push_bytes;
    logic [63:0] frame;
    logic [15:0] underrun;
  } frame_vec_t;

  frame_vec_t tab_a [3];
  frame_vec_t tab_b [4];

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;
  int bad_pops = 0;
  int pops_base = 0;
  logic [7:0]   fifo_q [$];
  logic [127:0] frames [$];

  int cyc = 0;
  int bitpos = 0;
  int last_rise = 0;
  int bck_period = 0;
  bit have_rise = 1'b0;
  logic bck_prev = 1'b0;
  logic [63:0] cur_data = '0;
  logic [63:0] cur_lrck = '0;

  // FIFO model: data valid the cycle after fifo_read.
  always @(posedge clk) begin
    if (fifo_read) begin
      if (fifo_q.size() > 0) begin
        fifo_data <= fifo_q.pop_front();
        pops++;
      end else begin
        bad_pops++;
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Deserializer: sample SDATA/LRCK on each BCK rise, 64 bits per frame.
  always @(negedge clk) begin
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d reached, expected end before 90000", cyc);
      $fatal(1);
    end
    if (running !== 1'b1) begin
      bitpos = 0;
      have_rise = 1'b0;
    end else if (dac_bck && !bck_prev) begin
      if (have_rise) bck_period = cyc - last_rise;
      last_rise = cyc;
      have_rise = 1'b1;
      cur_data[63-bitpos] = dac_sdata;
      cur_lrck[63-bitpos] = dac_lrck;
      if (bitpos == 63) begin
        frames.push_back({cur_lrck, cur_data});
        bitpos = 0;
      end else begin
        bitpos++;
      end
    end
    bck_prev = dac_bck;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(output logic [127:0] f, output bit ok);
    int n = 0;
    ok = 1'b0;
    f = '0;
    while (frames.size() == 0 && n < 1500) begin
      @(negedge clk);
      n++;
    end
    if (frames.size() > 0) begin
      f = frames.pop_front();
      ok = 1'b1;
    end else begin
      vectors++;
      miscompares++;
      $display("FAIL frame_timeout: no frame after %0d cycles, expected one", n);
    end
  endtask

  task automatic wait_running();
    int n = 0;
    while (running !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("running_start", 64'(running), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    fifo_q.delete();
    repeat (3) @(negedge clk);
    frames.delete();
    reset = 1'b1;
    pops_base = pops;
  endtask

  task automatic push_bytes(input int unsigned n, input logic [47:0] bytes);
    logic [47:0] b;
    b = bytes;
    for (int i = 0; i < int'(n); i++) begin
      fifo_q.push_back(b[47:40]);
      b = b << 8;
    end
  endtask

  task automatic run_vec(input string tag, input frame_vec_t v);
    logic [127:0] f;
    bit ok;
    repeat (v.push_delay) @(negedge clk);
    push_bytes(v.push_n, v.push_bytes);
    wait_frame(f, ok);
    if (ok) begin
      check({tag, "_data"}, f[63:0], v.frame);
      check({tag, "_lrck"}, f[127:64], LRCK_EXP);
    end
    check({tag, "_underrun"}, 64'(underrun_count), 64'(v.underrun));
  endtask

  initial begin
    logic [127:0] f;
    bit ok;
    int n;

    // Frame i of each run: bytes pushed just before waiting, expected frame and counter.
    tab_a[0] = '{0, 0, 48'h0,                64'h1234_5600_ABCD_EF00, 16'd0};
    tab_a[1] = '{6, 0, 48'h3141_5926_5358,   64'h0,                   16'd1};
    tab_a[2] = '{0, 0, 48'h0,                64'h3141_5900_2653_5800, 16'd1};
    tab_b[0] = '{3, 0, 48'hA1A2_A300_0000,   64'h0102_0300_0405_0600, 16'd0};
    tab_b[1] = '{0, 0, 48'h0,                64'h0,                   16'd1};
    tab_b[2] = '{3, 8, 48'hB1B2_B300_0000,   64'h0,                   16'd2};
    tab_b[3] = '{0, 0, 48'h0,                64'hA1A2_A300_B1B2_B300, 16'd2};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_fifo_read", 64'(fifo_read), 64'd0);
    check("rst_bck", 64'(dac_bck), 64'd0);
    check("rst_lrck", 64'(dac_lrck), 64'd0);
    check("rst_sdata", 64'(dac_sdata), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_underrun", 64'(underrun_count), 64'd0);
    reset = 1'b1;
    pops_base = pops;

    // Basic frame, underrun on empty FIFO, refill.
    push_bytes(6, 48'h1234_56AB_CDEF);
    enable = 1'b1;
    wait_running();
    for (int i = 0; i < 3; i++) begin
      run_vec($sformatf("a%0d", i), tab_a[i]);
      if (i == 0) check("bck_period", 64'(bck_period), 64'd8);
    end
    check("a_pops", 64'(pops - pops_base), 64'd12);

    // Partial fetch retained across two silent frames.
    do_reset();
    push_bytes(6, 48'h0102_0304_0506);
    enable = 1'b1;
    wait_running();
    for (int i = 0; i < 4; i++) run_vec($sformatf("b%0d", i), tab_b[i]);
    check("b_pops", 64'(pops - pops_base), 64'd12);

    // Enable dropped mid-left-slot, then restarted from staged data.
    do_reset();
    push_bytes(6, 48'h4142_4344_4546);
    push_bytes(6, 48'h4748_494A_4B4C);
    push_bytes(6, 48'h4D4E_4F50_5152);
    enable = 1'b1;
    wait_running();
    repeat (80) @(negedge clk);
    enable = 1'b0;
    wait_frame(f, ok);
    if (ok) check("c_frame1", f[63:0], 64'h4142_4300_4445_4600);
    repeat (20) @(negedge clk);
    check("c_stop_running", 64'(running), 64'd0);
    check("c_stop_bck", 64'(dac_bck), 64'd0);
    check("c_stop_lrck", 64'(dac_lrck), 64'd0);
    check("c_stop_sdata", 64'(dac_sdata), 64'd0);
    repeat (600) @(negedge clk);
    check("c_stop_pops", 64'(pops - pops_base), 64'd12);
    check("c_fifo_left", 64'(fifo_q.size()), 64'd6);
    check("c_no_frames", 64'(frames.size()), 64'd0);
    check("c_stop_underrun", 64'(underrun_count), 64'd0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    check("c_restart_running", 64'(running), 64'd1);
    wait_frame(f, ok);
    if (ok) check("c_frame2", f[63:0], 64'h4748_4900_4A4B_4C00);

    // Asynchronous reset mid-frame and mid-fetch after two pops.
    repeat (10) @(negedge clk);
    push_bytes(6, 48'h6162_6364_6566);
    push_bytes(2, 48'h6768_0000_0000);
    pops_base = pops;
    n = 0;
    while ((pops - pops_base) < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("d_two_pops", 64'(pops - pops_base), 64'd2);
    reset = 1'b0;
    #1;
    check("d_rst_fifo_read", 64'(fifo_read), 64'd0);
    check("d_rst_bck", 64'(dac_bck), 64'd0);
    check("d_rst_lrck", 64'(dac_lrck), 64'd0);
    check("d_rst_sdata", 64'(dac_sdata), 64'd0);
    check("d_rst_running", 64'(running), 64'd0);
    check("d_rst_underrun", 64'(underrun_count), 64'd0);
    repeat (3) @(negedge clk);
    frames.delete();
    pops_base = pops;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("d_no_pop_first", 64'(fifo_read), 64'd0);
    wait_running();
    wait_frame(f, ok);
    if (ok) check("d_frame", f[63:0], 64'h6364_6500_6667_6800);
    check("d_pops", 64'(pops - pops_base), 64'd6);

    // Saturation of the underrun counter.
    force u_dut.underrun_count = 16'hFFFD;
    @(negedge clk);
    release u_dut.underrun_count;
    wait_frame(f, ok);
    if (ok) check("e_frame_silent", f[63:0], 64'h0);
    check("e_count_fffe", 64'(underrun_count), 64'hFFFE);
    wait_frame(f, ok);
    check("e_count_ffff", 64'(underrun_count), 64'hFFFF);
    wait_frame(f, ok);
    wait_frame(f, ok);
    check("e_count_hold", 64'(underrun_count), 64'hFFFF);

    check("no_pop_when_empty", 64'(bad_pops), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_dac_serializer.md
SLOT_DAC_SERIALIZER -- requirements
Module: slot_dac_serializer

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per BCK half-period (legal range 1..255).
REQ-002 Parameter SAMPLE_BYTES, default 3, bytes per channel sample, MSB byte first.
REQ-003 clk  input  1  system clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  run request from the configuration controller.
REQ-006 fifo_data  input  8  RAM->DAC tracking FIFO read data, valid 1 cycle after fifo_read.
REQ-007 fifo_empty  input  1  FIFO holds no unread byte.
REQ-008 fifo_read  output  1  one-cycle pop strobe.
REQ-009 dac_bck  output  1  bit clock to slot pins.
REQ-010 dac_lrck  output  1  word clock; 0 = left, 1 = right.
REQ-011 dac_sdata  output  1  serial data, left-justified, MSB first.
REQ-012 underrun_count  output  16  frames replaced by silence, saturating.
REQ-013 running  output  1  high while frame timing is active.

Function
REQ-014 Frame: 64 BCK periods; 32 slots per channel; sample bits (8*SAMPLE_BYTES) in the first slots, remainder 0.
REQ-015 dac_bck toggles every CLK_DIV clk cycles while running; dac_sdata and dac_lrck change only on the cycle dac_bck falls.
REQ-016 MSB of the left sample appears on dac_sdata on the same falling edge where dac_lrck goes 0; no 1-bit I2S delay.
REQ-017 Fetch FSM states: IDLE, FETCH, READY.
REQ-018 IDLE -> FETCH when enable=1; FETCH issues fifo_read only in cycles where fifo_empty=0; at most one pop per cycle.
REQ-019 FETCH captures 2*SAMPLE_BYTES bytes into a staging register (left bytes, then right bytes), then -> READY; fifo_read never asserts in READY.
REQ-020 Frame boundary (falling BCK edge that starts a left slot): if READY, load shift register from staging and -> FETCH; otherwise load zeros, increment underrun_count (saturate at 0xFFFF) and retain partially captured bytes, FETCH continuing.
REQ-021 Pops never exceed 2*SAMPLE_BYTES per frame; byte-to-channel alignment is never lost across underruns.
REQ-022 Timing starts (running=1) on the first cycle READY is reached after enable rises; the first frame carries fetched data.
REQ-023 enable falling: current frame completes; at the next frame boundary running=0, BCK/LRCK/SDATA held 0; FETCH completes to READY and holds; no pops in READY.
REQ-024 enable re-asserted while READY with running=0: timing restarts next cycle with staged data.
REQ-025 Simultaneous frame boundary and final fetch byte capture: counts as not READY (silence, underrun++); the byte is still captured.

Reset
REQ-026 reset=0 asynchronously forces: fetch FSM IDLE, fifo_read=0, dac_bck=0, dac_lrck=0, dac_sdata=0, running=0, underrun_count=0, staging and shift register 0, all counters 0.
REQ-027 Reset mid-frame or mid-fetch discards partial data; no pop is issued in the first cycle after release.

Structure
REQ-028 A shared package (da_platform_pkg) holds SLOT_BITS=32, FRAME_SLOTS=64, the fetch-state encoding and the underrun counter width.
REQ-029 One sub-module, dac_frame_timer, generates BCK, LRCK, the falling-edge strobe and the frame-boundary strobe from CLK_DIV and running.

Verification
REQ-030 FIFO preloaded with 0x12 0x34 0x56 0xAB 0xCD 0xEF, enable=1, CLK_DIV=4 -> left slot bits 0x123456 then 8 zeros, right slot 0xABCDEF then 8 zeros; exactly 6 pops; BCK period = 8 clk.
REQ-031 FIFO empty at the second frame -> that frame is all zero, underrun_count=1; refill 6 bytes -> the third frame carries them with correct L/R alignment.
REQ-032 3 bytes available, then empty for 2 frames, then 3 more -> 2 silent frames, underrun_count=2; the next frame is L=first 3 bytes, R=last 3 bytes.
REQ-033 enable dropped mid-left-slot -> frame completes, then BCK/LRCK/SDATA 0, running=0, and no pops beyond the 6 staged bytes.
REQ-034 reset asserted mid-fetch after 2 pops -> all outputs 0 immediately; after release and enable, the next 6 bytes are popped fresh.
REQ-035 underrun_count preset near saturation by running with an empty FIFO (or forced) -> holds at 0xFFFF with no wrap.
